// File: rtl/timer_gen.sv
// ---------------------------------------------------------------------------
// timer_gen -- prescaled up-counter timer with one-shot / periodic modes.
//
// A start request latches mode, presc and top, then runs the counter in RUN.
// Each enabled clock advances a prescaler. When the prescaler reaches the
// latched divide value it wraps and the count takes one step. A step taken
// while count equals the latched terminal value is the terminal step:
//   - tick pulses for the following cycle;
//   - periodic mode reloads count to 0 and keeps running;
//   - one-shot mode holds count at top, moves to HOLD and raises done.
// stop aborts to IDLE from any state and has priority over start.
//
// Ports
//   clk    : clock; all state changes on its rising edge
//   reset  : asynchronous active-low reset
//   en     : count enable; only has an effect in RUN
//   start  : start/restart request (relatches configuration)
//   stop   : abort request
//   mode   : 0 = one-shot, 1 = periodic
//   presc  : prescale value P; one count step every P+1 enabled clocks
//   top    : terminal count T
//   count  : current count value (registered)
//   busy   : high while in RUN
//   tick   : one-cycle pulse after each terminal step (registered)
//   done   : one-shot completion flag, held until start, stop or reset
// ---------------------------------------------------------------------------
module timer_gen #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   top,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tick,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [PRESC_W-1:0] psc_cnt;
    logic [PRESC_W-1:0] cfg_presc;
    logic [WIDTH-1:0]   cfg_top;
    logic               cfg_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            psc_cnt   <= '0;
            tick      <= 1'b0;
            done      <= 1'b0;
            cfg_mode  <= 1'b0;
            cfg_presc <= '0;
            cfg_top   <= '0;
        end else begin
            // tick is a single-cycle pulse; only a terminal step re-arms it.
            tick <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                count   <= '0;
                psc_cnt <= '0;
                done    <= 1'b0;
            end else if (start) begin
                state     <= RUN;
                count     <= '0;
                psc_cnt   <= '0;
                done      <= 1'b0;
                cfg_mode  <= mode;
                cfg_presc <= presc;
                cfg_top   <= top;
            end else if (state == RUN && en) begin
                if (psc_cnt == cfg_presc) begin
                    psc_cnt <= '0;
                    if (count == cfg_top) begin
                        tick <= 1'b1;
                        if (cfg_mode) begin
                            count <= '0;
                        end else begin
                            // count stays at top; the run is finished.
                            state <= HOLD;
                            done  <= 1'b1;
                        end
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    psc_cnt <= psc_cnt + PRESC_W'(1);
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: doc/timer_gen.md
TIMER_GEN -- requirements
Module: timer_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning count and terminal-value width in bits (legal range 2..32).
REQ-002 SHALL have parameter PRESC_W, default 4, meaning prescaler divide-value width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable; 0 freezes prescaler and count while running.
REQ-006 SHALL have port start  input  1  start/restart request, sampled each edge.
REQ-007 SHALL have port stop  input  1  abort request, sampled each edge.
REQ-008 SHALL have port mode  input  1  0 = one-shot, 1 = periodic (auto-reload).
REQ-009 SHALL have port presc  input  PRESC_W  prescale value P; count advances once every P+1 enabled clocks.
REQ-010 SHALL have port top  input  WIDTH  terminal count T.
REQ-011 SHALL have port count  output  WIDTH  current count value, registered.
REQ-012 SHALL have port busy  output  1  high while in RUN.
REQ-013 SHALL have port tick  output  1  one-cycle registered pulse on terminal step.
REQ-014 SHALL have port done  output  1  one-shot completion flag, held until start, stop or reset.

Function
REQ-015 SHALL implement three states: IDLE, RUN, HOLD. busy = (state == RUN).
REQ-016 SHALL latch mode, presc and top into internal registers on every accepted start; later input changes SHALL NOT affect the run in progress.
REQ-017 In any state, stop=1 SHALL move to IDLE on the next edge with count=0, prescaler=0, done=0, tick=0; stop SHALL take priority over start, en and terminal step.
REQ-018 In any state, start=1 with stop=0 SHALL move to RUN with count=0, prescaler=0, done=0, configuration relatched (restart from RUN or HOLD allowed).
REQ-019 In RUN with en=1: prescaler SHALL increment each edge; when prescaler == P, prescaler SHALL clear and a count step SHALL occur on that edge.
REQ-020 Count step with count != T SHALL set count = count+1.
REQ-021 Count step with count == T (terminal step) SHALL assert tick for exactly the following cycle; periodic: count SHALL go to 0 and stay RUN; one-shot: count SHALL hold T, state SHALL go to HOLD, done SHALL set.
REQ-022 In RUN with en=0, prescaler, count and state SHALL hold; tick SHALL be 0.
REQ-023 tick SHALL be 0 in every cycle not immediately following a terminal step.
REQ-024 T=0: periodic SHALL pulse tick every P+1 enabled clocks with count constant 0; one-shot SHALL complete after P+1 enabled clocks.
REQ-025 Count arithmetic SHALL be unsigned, modulo 2^WIDTH; T = 2^WIDTH-1 SHALL wrap to 0 only via terminal step.
REQ-026 Terminal-step period SHALL be (T+1)*(P+1) enabled clocks.
REQ-027 In IDLE and HOLD, en SHALL have no effect; count SHALL hold.

Reset
REQ-028 reset=0 SHALL immediately, without a clock, force state IDLE, count=0, prescaler=0, busy=0, tick=0, done=0, latched configuration=0.
REQ-029 Reset deassertion mid-operation SHALL leave the block in IDLE; a new start is required.

Verification
REQ-030 reset pulsed low mid-RUN between edges -> count=0, busy=0, done=0 immediately; stays IDLE after release.
REQ-031 mode=1, P=0, T=9, start one cycle, en=1 -> count 0,1..9,0..; tick high 1 cycle after each 9->0 step, period 10 clocks.
REQ-032 mode=0, P=2, T=3, start -> count steps every 3 clocks; done=1, busy=0, count=3 after 12 clocks in RUN; single tick.
REQ-033 mode=1, P=0, T=255, run 256 clocks -> count wraps 255->0 with one tick; en=0 for 5 clocks mid-run -> count frozen, period stretched to 261.
REQ-034 start and stop asserted together during RUN -> IDLE, count=0; start alone during HOLD -> RUN, done=0, count=0.
REQ-035 top/presc changed mid-run -> timing unchanged until next start.
